// File: rtl/mem_access_sequencer_pkg.sv
// Shared LC-3b types and opcode helpers used by the MEM-stage data-memory sequencer.
package lc3b_types;

    typedef logic [3:0]  lc3b_opcode;
    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    localparam lc3b_opcode OP_BR   = 4'b0000;
    localparam lc3b_opcode OP_ADD  = 4'b0001;
    localparam lc3b_opcode OP_LDB  = 4'b0010;
    localparam lc3b_opcode OP_STB  = 4'b0011;
    localparam lc3b_opcode OP_JSR  = 4'b0100;
    localparam lc3b_opcode OP_AND  = 4'b0101;
    localparam lc3b_opcode OP_LDR  = 4'b0110;
    localparam lc3b_opcode OP_STR  = 4'b0111;
    localparam lc3b_opcode OP_RTI  = 4'b1000;
    localparam lc3b_opcode OP_NOT  = 4'b1001;
    localparam lc3b_opcode OP_LDI  = 4'b1010;
    localparam lc3b_opcode OP_STI  = 4'b1011;
    localparam lc3b_opcode OP_JMP  = 4'b1100;
    localparam lc3b_opcode OP_SHF  = 4'b1101;
    localparam lc3b_opcode OP_LEA  = 4'b1110;
    localparam lc3b_opcode OP_TRAP = 4'b1111;

    localparam lc3b_mem_wmask WMASK_WORD = 2'b11;
    localparam lc3b_mem_wmask WMASK_LOW  = 2'b01;
    localparam lc3b_mem_wmask WMASK_HIGH = 2'b10;

    function automatic logic is_mem_op(input lc3b_opcode op);
        logic r;
        case (op)
            OP_LDR, OP_LDB, OP_STR, OP_STB, OP_LDI, OP_STI: r = 1'b1;
            default:                                        r = 1'b0;
        endcase
        return r;
    endfunction

    // Indirect ops fetch a pointer first, so their first access is always a read.
    function automatic logic is_indirect_op(input lc3b_opcode op);
        return (op == OP_LDI) || (op == OP_STI);
    endfunction

    function automatic logic is_direct_store(input lc3b_opcode op);
        return (op == OP_STR) || (op == OP_STB);
    endfunction

    function automatic logic is_byte_op(input lc3b_opcode op);
        return (op == OP_LDB) || (op == OP_STB);
    endfunction

endpackage

// File: rtl/mem_access_sequencer_byte_lane_align.sv
// Byte-lane steering: load byte select with sign extension, store byte replication and mask.
module byte_lane_align
    import lc3b_types::*;
(
    input  logic [3:0]  opcode,
    input  logic [15:0] address,
    input  logic [15:0] store_data,
    input  logic [15:0] rdata,
    output logic [15:0] wdata,
    output logic [1:0]  wmask,
    output logic [15:0] load_value
);

    logic [7:0] byte_sel;

    always_comb begin
        byte_sel   = address[0] ? rdata[15:8] : rdata[7:0];
        load_value = rdata;
        wdata      = store_data;
        wmask      = WMASK_WORD;

        if (opcode == OP_LDB) begin
            load_value = {{8{byte_sel[7]}}, byte_sel};
        end

        // The addressed byte lane is chosen by the mask, so both lanes carry the data.
        if (opcode == OP_STB) begin
            wdata = {store_data[7:0], store_data[7:0]};
            wmask = address[0] ? WMASK_HIGH : WMASK_LOW;
        end
    end

endmodule

// File: rtl/mem_access_sequencer.sv
// MEM-stage data-memory sequencer: issues one (direct) or two (indirect) d-memory
// accesses per instruction and reports stall / indirect phase to hazard detection.
module mem_access_sequencer
    import lc3b_types::*;
#(
    parameter int GAP_CYCLES = 1
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic [3:0]  mem_opcode,
    input  logic [15:0] mem_address,
    input  logic [15:0] mem_store_data,
    input  logic        advance,
    input  logic        d_mem_resp,
    input  logic [15:0] d_mem_rdata,
    output logic        d_mem_read,
    output logic        d_mem_write,
    output logic [15:0] d_mem_address,
    output logic [15:0] d_mem_wdata,
    output logic [1:0]  d_mem_byte_enable,
    output logic [15:0] load_data,
    output logic        mem_done,
    output logic        mem_stall,
    output logic        indirect_phase
);

    // state  | meaning
    // IDLE   | no access in flight; samples the MEM-stage instruction
    // FIRST  | direct access, or pointer fetch of LDI/STI
    // GAP    | request-free spacing between the two indirect accesses
    // SECOND | indirect access through the fetched pointer
    // HOLD   | access finished, waiting for the pipeline to advance
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FIRST  = 3'd1,
        S_GAP    = 3'd2,
        S_SECOND = 3'd3,
        S_HOLD   = 3'd4
    } state_t;

    localparam logic [1:0] GAP_LOAD = 2'(GAP_CYCLES - 1);

    state_t        state, state_d;
    lc3b_opcode    op_q;
    lc3b_word      addr_q;
    lc3b_word      sdata_q;
    lc3b_word      ptr_q;
    logic [1:0]    gap_cnt;

    logic          latch_en;
    logic          ptr_en;
    logic          load_en;

    lc3b_word      align_wdata;
    lc3b_mem_wmask align_mask;
    lc3b_word      align_load;
    lc3b_word      first_addr;

    byte_lane_align u_align (
        .opcode     (op_q),
        .address    (addr_q),
        .store_data (sdata_q),
        .rdata      (d_mem_rdata),
        .wdata      (align_wdata),
        .wmask      (align_mask),
        .load_value (align_load)
    );

    assign first_addr = is_byte_op(op_q) ? addr_q : {addr_q[15:1], 1'b0};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q    <= OP_BR;
            addr_q  <= '0;
            sdata_q <= '0;
        end else if (latch_en) begin
            op_q    <= mem_opcode;
            addr_q  <= mem_address;
            sdata_q <= mem_store_data;
        end
    end

    // Pointer and gap timer are loaded together when the pointer fetch completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q   <= '0;
            gap_cnt <= '0;
        end else if (ptr_en) begin
            ptr_q   <= {d_mem_rdata[15:1], 1'b0};
            gap_cnt <= GAP_LOAD;
        end else if (state == S_GAP && gap_cnt != 2'd0) begin
            gap_cnt <= gap_cnt - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_data <= '0;
        end else if (load_en) begin
            load_data <= align_load;
        end
    end

    always_comb begin
        state_d           = state;
        latch_en          = 1'b0;
        ptr_en            = 1'b0;
        load_en           = 1'b0;
        mem_done          = 1'b0;
        mem_stall         = 1'b0;
        d_mem_read        = 1'b0;
        d_mem_write       = 1'b0;
        d_mem_address     = '0;
        d_mem_wdata       = '0;
        d_mem_byte_enable = '0;

        case (state)
            S_IDLE: begin
                if (mem_valid && is_mem_op(mem_opcode)) begin
                    latch_en  = 1'b1;
                    mem_stall = 1'b1;
                    state_d   = S_FIRST;
                end
            end

            S_FIRST: begin
                mem_stall     = 1'b1;
                d_mem_address = first_addr;
                if (is_direct_store(op_q)) begin
                    d_mem_write       = 1'b1;
                    d_mem_wdata       = align_wdata;
                    d_mem_byte_enable = align_mask;
                end else begin
                    d_mem_read = 1'b1;
                end

                if (d_mem_resp) begin
                    if (is_indirect_op(op_q)) begin
                        ptr_en  = 1'b1;
                        state_d = S_GAP;
                    end else begin
                        mem_done = 1'b1;
                        load_en  = ~is_direct_store(op_q);
                        state_d  = advance ? S_IDLE : S_HOLD;
                    end
                end
            end

            S_GAP: begin
                mem_stall = 1'b1;
                if (gap_cnt == 2'd0) begin
                    state_d = S_SECOND;
                end
            end

            S_SECOND: begin
                mem_stall     = 1'b1;
                d_mem_address = ptr_q;
                if (op_q == OP_STI) begin
                    d_mem_write       = 1'b1;
                    d_mem_wdata       = sdata_q;
                    d_mem_byte_enable = WMASK_WORD;
                end else begin
                    d_mem_read = 1'b1;
                end

                if (d_mem_resp) begin
                    mem_done = 1'b1;
                    load_en  = (op_q == OP_LDI);
                    state_d  = advance ? S_IDLE : S_HOLD;
                end
            end

            S_HOLD: begin
                if (advance) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The completing cycle releases the pipeline.
        if (mem_done) begin
            mem_stall = 1'b0;
        end
    end

    assign indirect_phase = (state == S_GAP) || (state == S_SECOND);

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer: vector table for direct ops plus hand sequences.
module tb_mem_access_sequencer;

    localparam logic [3:0] T_ADD = 4'b0001;
    localparam logic [3:0] T_LDB = 4'b0010;
    localparam logic [3:0] T_STB = 4'b0011;
    localparam logic [3:0] T_LDR = 4'b0110;
    localparam logic [3:0] T_STR = 4'b0111;
    localparam logic [3:0] T_LDI = 4'b1010;
    localparam logic [3:0] T_STI = 4'b1011;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid;
    logic [3:0]  mem_opcode;
    logic [15:0] mem_address;
    logic [15:0] mem_store_data;
    logic        advance;
    logic        d_mem_resp;
    logic [15:0] d_mem_rdata;
    logic        d_mem_read;
    logic        d_mem_write;
    logic [15:0] d_mem_address;
    logic [15:0] d_mem_wdata;
    logic [1:0]  d_mem_byte_enable;
    logic [15:0] load_data;
    logic        mem_done;
    logic        mem_stall;
    logic        indirect_phase;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mem_access_sequencer #(.GAP_CYCLES(1)) dut (
        .clk               (clk),
        .reset             (reset),
        .mem_valid         (mem_valid),
        .mem_opcode        (mem_opcode),
        .mem_address       (mem_address),
        .mem_store_data    (mem_store_data),
        .advance           (advance),
        .d_mem_resp        (d_mem_resp),
        .d_mem_rdata       (d_mem_rdata),
        .d_mem_read        (d_mem_read),
        .d_mem_write       (d_mem_write),
        .d_mem_address     (d_mem_address),
        .d_mem_wdata       (d_mem_wdata),
        .d_mem_byte_enable (d_mem_byte_enable),
        .load_data         (load_data),
        .mem_done          (mem_done),
        .mem_stall         (mem_stall),
        .indirect_phase    (indirect_phase)
    );

    typedef struct {
        logic [3:0]  op;
        logic [15:0] addr;
        logic [15:0] sd;
        logic [15:0] rdata;
        int          wait_cyc;
        logic        is_wr;
        logic [15:0] exp_addr;
        logic [15:0] exp_wdata;
        logic [1:0]  exp_mask;
        logic [15:0] exp_load;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int held;
        int idle;

        vecs[0] = '{T_LDR, 16'h3001, 16'h0000, 16'hBEEF, 2, 1'b0, 16'h3000, 16'h0000, 2'b00, 16'hBEEF};
        vecs[1] = '{T_LDB, 16'h4001, 16'h0000, 16'h8012, 0, 1'b0, 16'h4001, 16'h0000, 2'b00, 16'hFF80};
        vecs[2] = '{T_LDB, 16'h4000, 16'h0000, 16'h8012, 1, 1'b0, 16'h4000, 16'h0000, 2'b00, 16'h0012};
        vecs[3] = '{T_STB, 16'h5001, 16'h00A5, 16'hDEAD, 1, 1'b1, 16'h5001, 16'hA5A5, 2'b10, 16'h0012};
        vecs[4] = '{T_STR, 16'h5003, 16'h1234, 16'hDEAD, 0, 1'b1, 16'h5002, 16'h1234, 2'b11, 16'h0012};
        vecs[5] = '{T_STB, 16'h5000, 16'h1234, 16'hDEAD, 2, 1'b1, 16'h5000, 16'h3434, 2'b01, 16'h0012};
        vecs[6] = '{T_LDB, 16'h4001, 16'h0000, 16'h7F00, 0, 1'b0, 16'h4001, 16'h0000, 2'b00, 16'h007F};
        vecs[7] = '{T_LDR, 16'h2000, 16'h0000, 16'h0000, 1, 1'b0, 16'h2000, 16'h0000, 2'b00, 16'h0000};

        reset = 1'b1; mem_valid = 1'b0; mem_opcode = T_ADD; mem_address = '0;
        mem_store_data = '0; advance = 1'b0; d_mem_resp = 1'b0; d_mem_rdata = '0;
        #2;
        check("rst_read",  d_mem_read, 0);
        check("rst_write", d_mem_write, 0);
        check("rst_addr",  d_mem_address, 0);
        check("rst_load",  load_data, 0);
        check("rst_stall", mem_stall, 0);
        check("rst_ind",   indirect_phase, 0);
        tick(); tick();
        reset = 1'b0;
        tick();

        // Non-memory op must never stall or request.
        mem_valid = 1'b1; mem_opcode = T_ADD;
        #1 check("nonmem_stall", mem_stall, 0);
        tick();
        check("nonmem_req", {d_mem_read, d_mem_write}, 0);
        mem_valid = 1'b0;

        for (int i = 0; i < 8; i++) begin
            mem_valid = 1'b1; mem_opcode = vecs[i].op;
            mem_address = vecs[i].addr; mem_store_data = vecs[i].sd;
            #1 check($sformatf("v%0d_idle_stall", i), mem_stall, 1);
            tick();
            check($sformatf("v%0d_read", i),  d_mem_read, !vecs[i].is_wr);
            check($sformatf("v%0d_write", i), d_mem_write, vecs[i].is_wr);
            check($sformatf("v%0d_addr", i),  d_mem_address, vecs[i].exp_addr);
            if (vecs[i].is_wr) begin
                check($sformatf("v%0d_wdata", i), d_mem_wdata, vecs[i].exp_wdata);
                check($sformatf("v%0d_mask", i),  d_mem_byte_enable, vecs[i].exp_mask);
            end
            held = 0;
            for (int w = 0; w <= vecs[i].wait_cyc; w++) begin
                if (d_mem_read || d_mem_write) held++;
                if (w == vecs[i].wait_cyc) begin
                    d_mem_resp = 1'b1; d_mem_rdata = vecs[i].rdata; advance = 1'b1;
                    #1;
                    check($sformatf("v%0d_done", i), mem_done, 1);
                    check($sformatf("v%0d_done_stall", i), mem_stall, 0);
                end else begin
                    check($sformatf("v%0d_wait_done", i), mem_done, 0);
                end
                tick();
            end
            d_mem_resp = 1'b0; advance = 1'b0; mem_valid = 1'b0; d_mem_rdata = 16'hC3C3;
            check($sformatf("v%0d_held", i), held, vecs[i].wait_cyc + 1);
            check($sformatf("v%0d_load", i), load_data, vecs[i].exp_load);
            check($sformatf("v%0d_after_req", i), {d_mem_read, d_mem_write}, 0);
            check($sformatf("v%0d_after_done", i), mem_done, 0);
        end

        // LDI through pointer 0x7003 -> second access at 0x7002.
        mem_valid = 1'b1; mem_opcode = T_LDI; mem_address = 16'h6000;
        tick();
        check("ldi_first_read", d_mem_read, 1);
        check("ldi_first_addr", d_mem_address, 16'h6000);
        check("ldi_first_ind", indirect_phase, 0);
        d_mem_resp = 1'b1; d_mem_rdata = 16'h7003;
        #1 check("ldi_first_nodone", mem_done, 0);
        check("ldi_first_stall", mem_stall, 1);
        tick();
        d_mem_resp = 1'b0;
        check("ldi_gap_ind", indirect_phase, 1);
        check("ldi_gap_stall", mem_stall, 1);
        idle = 0;
        for (int k = 0; k < 8; k++) begin
            if (d_mem_read || d_mem_write) break;
            idle++;
            tick();
        end
        check("ldi_gap_len", idle, 1);
        check("ldi_second_read", d_mem_read, 1);
        check("ldi_second_addr", d_mem_address, 16'h7002);
        check("ldi_second_ind", indirect_phase, 1);
        d_mem_resp = 1'b1; d_mem_rdata = 16'h1234; advance = 1'b1;
        #1 check("ldi_done", mem_done, 1);
        tick();
        d_mem_resp = 1'b0; advance = 1'b0; mem_valid = 1'b0;
        check("ldi_load", load_data, 16'h1234);
        check("ldi_after_ind", indirect_phase, 0);

        // STI completes with advance low -> HOLD, no re-issue until advance.
        mem_valid = 1'b1; mem_opcode = T_STI; mem_address = 16'h6101; mem_store_data = 16'hABCD;
        tick();
        check("sti_first_addr", d_mem_address, 16'h6100);
        check("sti_first_read", d_mem_read, 1);
        d_mem_resp = 1'b1; d_mem_rdata = 16'h8001;
        tick();
        d_mem_resp = 1'b0;
        tick();
        check("sti_second_write", d_mem_write, 1);
        check("sti_second_addr", d_mem_address, 16'h8000);
        check("sti_second_wdata", d_mem_wdata, 16'hABCD);
        check("sti_second_mask", d_mem_byte_enable, 2'b11);
        d_mem_resp = 1'b1;
        #1 check("sti_done", mem_done, 1);
        tick();
        d_mem_resp = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("hold%0d_req", k), {d_mem_read, d_mem_write}, 0);
            check($sformatf("hold%0d_stall", k), mem_stall, 0);
            check($sformatf("hold%0d_done", k), mem_done, 0);
            tick();
        end
        check("hold_load", load_data, 16'h1234);
        advance = 1'b1;
        tick();
        advance = 1'b0; mem_opcode = T_LDR; mem_address = 16'h3456;
        check("next_idle_req", d_mem_read, 0);
        check("next_idle_stall", mem_stall, 1);
        tick();
        check("next_first_read", d_mem_read, 1);
        check("next_first_addr", d_mem_address, 16'h3456);
        d_mem_resp = 1'b1; d_mem_rdata = 16'h5555; advance = 1'b1;
        tick();
        d_mem_resp = 1'b0; advance = 1'b0; mem_valid = 1'b0;
        check("next_load", load_data, 16'h5555);

        // Reset during SECOND, then a stale response.
        mem_valid = 1'b1; mem_opcode = T_LDI; mem_address = 16'h6200;
        tick();
        d_mem_resp = 1'b1; d_mem_rdata = 16'h9000;
        tick();
        d_mem_resp = 1'b0;
        tick();
        check("rstmid_second_read", d_mem_read, 1);
        check("rstmid_second_addr", d_mem_address, 16'h9000);
        #2 reset = 1'b1;
        #1;
        check("rstmid_read", d_mem_read, 0);
        check("rstmid_addr", d_mem_address, 0);
        check("rstmid_ind", indirect_phase, 0);
        check("rstmid_load", load_data, 0);
        tick();
        reset = 1'b0; mem_valid = 1'b0;
        d_mem_resp = 1'b1; d_mem_rdata = 16'hFFFF;
        #1 check("stale_done", mem_done, 0);
        tick();
        d_mem_resp = 1'b0;
        check("stale_load", load_data, 0);
        check("stale_req", {d_mem_read, d_mem_write}, 0);
        check("stale_stall", mem_stall, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
